// File: rtl/control_sequencer.sv
// control_sequencer: microcode control sequencer for the 8-bit computer.
// Runs a T-state step counter (fetch T0/T1, execute T2..T4) and decodes
// {opcode, step, carry, zero} into individual bus/register strobes.
// Optional build macro: EARLY_STEP_RESET_EN -- when defined, the step counter
// returns to T0 right after each opcode's last active step instead of
// running idle steps up to N_STEPS-1.
module control_sequencer #(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned N_STEPS = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            step_en,
    input  logic [OP_W-1:0] opcode,
    input  logic            carry,
    input  logic            zero,
    output logic            pc_clr,
    output logic            pc_oe,
    output logic            pc_inc,
    output logic            pc_jmp,
    output logic            mar_in,
    output logic            ram_oe,
    output logic            ram_in,
    output logic            ir_in,
    output logic            ir_oe,
    output logic            a_in,
    output logic            a_oe,
    output logic            b_in,
    output logic            alu_oe,
    output logic            alu_sub,
    output logic            flag_in,
    output logic            out_in,
    output logic            hlt,
    output logic [2:0]      step
);

    typedef enum logic {
        MODE_RUN,
        MODE_HALT
    } mode_t;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = OP_W'(4'b0000),
        OP_LDA = OP_W'(4'b0001),
        OP_ADD = OP_W'(4'b0010),
        OP_SUB = OP_W'(4'b0011),
        OP_STA = OP_W'(4'b0100),
        OP_LDI = OP_W'(4'b0101),
        OP_JMP = OP_W'(4'b0110),
        OP_JC  = OP_W'(4'b0111),
        OP_JZ  = OP_W'(4'b1000),
        OP_OUT = OP_W'(4'b1110),
        OP_HLT = OP_W'(4'b1111)
    } op_t;

    localparam logic [2:0] T0     = 3'd0;
    localparam logic [2:0] T1     = 3'd1;
    localparam logic [2:0] T2     = 3'd2;
    localparam logic [2:0] T3     = 3'd3;
    localparam logic [2:0] T4     = 3'd4;
    localparam logic [2:0] LAST_T = 3'(N_STEPS - 1);

    logic [2:0] step_q;
    logic [2:0] step_d;
    mode_t      mode_q;
    mode_t      mode_d;
    logic [2:0] last_step;

    // Last active T-state of the current opcode; the counter wraps after it.
    always_comb begin
        last_step = LAST_T;
`ifdef EARLY_STEP_RESET_EN
        case (opcode)
            OP_LDA, OP_STA:                        last_step = T3;
            OP_ADD, OP_SUB:                        last_step = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
            OP_HLT:                                last_step = T2;
            default:                               last_step = T1;
        endcase
`endif
    end

    // State register: synchronous active-low reset back to T0, running.
    always_ff @(posedge clk) begin
        if (!clr) begin
            step_q <= '0;
            mode_q <= MODE_RUN;
        end else begin
            step_q <= step_d;
            mode_q <= mode_d;
        end
    end

    // Next step / halt: advance only when gated and running; HLT at T2 freezes.
    // The >= compare keeps the counter bounded if opcode changes mid-instruction.
    always_comb begin
        step_d = step_q;
        mode_d = mode_q;
        if (mode_q == MODE_RUN && step_en) begin
            if (step_q == T2 && opcode == OP_HLT) begin
                mode_d = MODE_HALT;
                step_d = '0;
            end else if (step_q >= last_step || step_q == LAST_T) begin
                step_d = '0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    // Control word decode from registered step, opcode and flags.
    always_comb begin
        pc_oe   = 1'b0;
        pc_inc  = 1'b0;
        pc_jmp  = 1'b0;
        mar_in  = 1'b0;
        ram_oe  = 1'b0;
        ram_in  = 1'b0;
        ir_in   = 1'b0;
        ir_oe   = 1'b0;
        a_in    = 1'b0;
        a_oe    = 1'b0;
        b_in    = 1'b0;
        alu_oe  = 1'b0;
        alu_sub = 1'b0;
        flag_in = 1'b0;
        out_in  = 1'b0;
        hlt     = 1'b0;
        if (mode_q == MODE_HALT) begin
            hlt = 1'b1;
        end else if (step_q == T0) begin
            pc_oe  = 1'b1;
            mar_in = 1'b1;
        end else if (step_q == T1) begin
            ram_oe = 1'b1;
            ir_in  = 1'b1;
            pc_inc = 1'b1;
        end else begin
            case (opcode)
                OP_LDA: begin
                    if (step_q == T2) begin
                        ir_oe  = 1'b1;
                        mar_in = 1'b1;
                    end else if (step_q == T3) begin
                        ram_oe = 1'b1;
                        a_in   = 1'b1;
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (step_q == T2) begin
                        ir_oe  = 1'b1;
                        mar_in = 1'b1;
                    end else if (step_q == T3) begin
                        ram_oe = 1'b1;
                        b_in   = 1'b1;
                    end else if (step_q == T4) begin
                        alu_oe  = 1'b1;
                        a_in    = 1'b1;
                        flag_in = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end
                end
                OP_STA: begin
                    if (step_q == T2) begin
                        ir_oe  = 1'b1;
                        mar_in = 1'b1;
                    end else if (step_q == T3) begin
                        a_oe   = 1'b1;
                        ram_in = 1'b1;
                    end
                end
                OP_LDI: begin
                    if (step_q == T2) begin
                        ir_oe = 1'b1;
                        a_in  = 1'b1;
                    end
                end
                OP_JMP: begin
                    if (step_q == T2) begin
                        ir_oe  = 1'b1;
                        pc_jmp = 1'b1;
                    end
                end
                OP_JC: begin
                    if (step_q == T2) begin
                        ir_oe  = 1'b1;
                        pc_jmp = carry;
                    end
                end
                OP_JZ: begin
                    if (step_q == T2) begin
                        ir_oe  = 1'b1;
                        pc_jmp = zero;
                    end
                end
                OP_OUT: begin
                    if (step_q == T2) begin
                        a_oe   = 1'b1;
                        out_in = 1'b1;
                    end
                end
                OP_HLT: begin
                    if (step_q == T2) begin
                        hlt = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pc_clr = ~clr;
    assign step   = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a
// randomized run, each cycle compared against a table-driven reference model.
module tb_control_sequencer;

    logic       clk;
    logic       clr;
    logic       step_en;
    logic [3:0] opcode;
    logic       carry;
    logic       zero;
    logic pc_clr, pc_oe, pc_inc, pc_jmp, mar_in, ram_oe, ram_in, ir_in, ir_oe;
    logic a_in, a_oe, b_in, alu_oe, alu_sub, flag_in, out_in, hlt;
    logic [2:0] step;

    control_sequencer #(.OP_W(4), .N_STEPS(5)) dut (
        .clk(clk), .clr(clr), .step_en(step_en), .opcode(opcode),
        .carry(carry), .zero(zero),
        .pc_clr(pc_clr), .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_jmp(pc_jmp),
        .mar_in(mar_in), .ram_oe(ram_oe), .ram_in(ram_in), .ir_in(ir_in),
        .ir_oe(ir_oe), .a_in(a_in), .a_oe(a_oe), .b_in(b_in),
        .alu_oe(alu_oe), .alu_sub(alu_sub), .flag_in(flag_in),
        .out_in(out_in), .hlt(hlt), .step(step)
    );

    always #5 clk = ~clk;

    // Control word bit positions (bit 0 = pc_clr).
    localparam logic [16:0] M_PC_CLR  = 17'h00001;
    localparam logic [16:0] M_PC_OE   = 17'h00002;
    localparam logic [16:0] M_PC_INC  = 17'h00004;
    localparam logic [16:0] M_PC_JMP  = 17'h00008;
    localparam logic [16:0] M_MAR_IN  = 17'h00010;
    localparam logic [16:0] M_RAM_OE  = 17'h00020;
    localparam logic [16:0] M_RAM_IN  = 17'h00040;
    localparam logic [16:0] M_IR_IN   = 17'h00080;
    localparam logic [16:0] M_IR_OE   = 17'h00100;
    localparam logic [16:0] M_A_IN    = 17'h00200;
    localparam logic [16:0] M_A_OE    = 17'h00400;
    localparam logic [16:0] M_B_IN    = 17'h00800;
    localparam logic [16:0] M_ALU_OE  = 17'h01000;
    localparam logic [16:0] M_ALU_SUB = 17'h02000;
    localparam logic [16:0] M_FLAG_IN = 17'h04000;
    localparam logic [16:0] M_OUT_IN  = 17'h08000;
    localparam logic [16:0] M_HLT     = 17'h10000;

    logic [16:0] cw;
    assign cw = {hlt, out_in, flag_in, alu_sub, alu_oe, b_in, a_oe, a_in,
                 ir_oe, ir_in, ram_in, ram_oe, mar_in, pc_jmp, pc_inc, pc_oe, pc_clr};

    // Reference model: microcode table indexed [opcode][T-state], plus
    // instruction position and halted flag.
    logic [16:0] ucode [16][5];
    int          m_step;
    bit          m_halted;
    int          compared;
    int          mismatched;

    function automatic int instr_len(input logic [3:0] op);
`ifdef EARLY_STEP_RESET_EN
        case (op)
            4'd1, 4'd4:                    return 4;
            4'd2, 4'd3:                    return 5;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd14,
            4'd15:                         return 3;
            default:                       return 2;
        endcase
`else
        return 5;
`endif
    endfunction

    function automatic logic [16:0] expected_cw();
        logic [16:0] w;
        if (m_halted) w = M_HLT;
        else begin
            w = ucode[opcode][m_step];
            if (m_step == 2 && opcode == 4'd7 && carry) w = w | M_PC_JMP;
            if (m_step == 2 && opcode == 4'd8 && zero)  w = w | M_PC_JMP;
        end
        if (!clr) w = w | M_PC_CLR;
        return w;
    endfunction

    task automatic model_edge();
        if (!clr) begin
            m_step   = 0;
            m_halted = 0;
        end else if (!m_halted && step_en) begin
            if (m_step == 2 && opcode == 4'd15) begin
                m_halted = 1;
                m_step   = 0;
            end else if (m_step + 1 >= instr_len(opcode)) begin
                m_step = 0;
            end else begin
                m_step = m_step + 1;
            end
        end
    endtask

    // Drive inputs at the falling edge, check the combinational outputs,
    // then let one rising edge pass and advance the model.
    task automatic apply(input bit c_clr, input bit c_en, input logic [3:0] c_op,
                         input bit c_carry, input bit c_zero, input string tag);
        logic [16:0] exp_w;
        logic [2:0]  exp_s;
        clr     = c_clr;
        step_en = c_en;
        opcode  = c_op;
        carry   = c_carry;
        zero    = c_zero;
        #1;
        exp_w = expected_cw();
        exp_s = 3'(m_step);
        compared++;
        assert (cw === exp_w) else begin
            mismatched++;
            $error("FAIL %s cw: observed %h expected %h (step %0d op %0d)", tag, cw, exp_w, m_step, c_op);
        end
        compared++;
        assert (step === exp_s) else begin
            mismatched++;
            $error("FAIL %s step: observed %0d expected %0d", tag, step, exp_s);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [3:0] op, input bit c, input bit z, input string tag);
        int k;
        k = 0;
        do begin
            apply(1, 1, op, c, z, tag);
            k++;
        end while (m_step != 0 && !m_halted && k < 8);
    endtask

    // Counts cycles until the DUT's own step returns to T0.
    task automatic measure_len(input logic [3:0] op, input int exp_len, input string tag);
        int n;
        n = 0;
        do begin
            apply(1, 1, op, 0, 0, tag);
            n++;
        end while (step !== 3'd0 && n < 10);
        compared++;
        assert (n === exp_len) else begin
            mismatched++;
            $error("FAIL %s length: observed %0d expected %0d", tag, n, exp_len);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int o = 0; o < 16; o++) begin
            for (int s = 0; s < 5; s++) ucode[o][s] = '0;
            ucode[o][0] = M_PC_OE | M_MAR_IN;
            ucode[o][1] = M_RAM_OE | M_IR_IN | M_PC_INC;
        end
        ucode[1][2]  = M_IR_OE | M_MAR_IN;   ucode[1][3] = M_RAM_OE | M_A_IN;
        ucode[2][2]  = M_IR_OE | M_MAR_IN;   ucode[2][3] = M_RAM_OE | M_B_IN;
        ucode[2][4]  = M_ALU_OE | M_A_IN | M_FLAG_IN;
        ucode[3][2]  = M_IR_OE | M_MAR_IN;   ucode[3][3] = M_RAM_OE | M_B_IN;
        ucode[3][4]  = M_ALU_OE | M_A_IN | M_FLAG_IN | M_ALU_SUB;
        ucode[4][2]  = M_IR_OE | M_MAR_IN;   ucode[4][3] = M_A_OE | M_RAM_IN;
        ucode[5][2]  = M_IR_OE | M_A_IN;
        ucode[6][2]  = M_IR_OE | M_PC_JMP;
        ucode[7][2]  = M_IR_OE;
        ucode[8][2]  = M_IR_OE;
        ucode[14][2] = M_A_OE | M_OUT_IN;
        ucode[15][2] = M_HLT;

        clk = 0; clr = 0; step_en = 0; opcode = '0; carry = 0; zero = 0;
        // First edge establishes a known state; nothing is checked before it.
        @(posedge clk);
        @(negedge clk);
        m_step = 0; m_halted = 0;

        // Reset and plain NOP stepping with wrap.
        apply(0, 1, 4'd0, 0, 0, "reset");
        for (int i = 0; i < 6; i++) apply(1, 1, 4'd0, 0, 0, "nop");

        // ADD / SUB.
        run_instr(4'd2, 0, 0, "add");
        run_instr(4'd3, 0, 0, "sub");

        // Conditional jumps.
        run_instr(4'd7, 0, 0, "jc_c0");
        run_instr(4'd7, 1, 0, "jc_c1");
        run_instr(4'd8, 0, 1, "jz_z1");
        run_instr(4'd8, 1, 0, "jz_z0");
        run_instr(4'd6, 0, 0, "jmp");
        run_instr(4'd4, 0, 0, "sta");
        run_instr(4'd14, 0, 0, "out");

        // Halt, frozen with opcode/step_en toggling, then reset out of it.
        run_instr(4'd15, 0, 0, "hlt");
        for (int i = 0; i < 10; i++)
            apply(1, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), 1'($urandom), "halted");
        apply(0, 1, 4'd15, 0, 0, "hlt_clr");
        apply(1, 1, 4'd0, 0, 0, "after_hlt");
        apply(0, 1, 4'd0, 0, 0, "realign");

        // Single-step hold at T3 of LDA.
        apply(1, 1, 4'd1, 0, 0, "lda");
        apply(1, 1, 4'd1, 0, 0, "lda");
        apply(1, 1, 4'd1, 0, 0, "lda");
        for (int i = 0; i < 3; i++) apply(1, 0, 4'd1, 0, 0, "lda_hold");
        apply(1, 1, 4'd1, 0, 0, "lda_release");
        apply(0, 1, 4'd0, 0, 0, "realign2");

        // Instruction lengths for a short program stream.
`ifdef EARLY_STEP_RESET_EN
        measure_len(4'd5, 3, "len_ldi");
        measure_len(4'd14, 3, "len_out");
        measure_len(4'd0, 2, "len_nop");
        measure_len(4'd2, 5, "len_add");
`else
        measure_len(4'd5, 5, "len_ldi");
        measure_len(4'd14, 5, "len_out");
        measure_len(4'd0, 5, "len_nop");
        measure_len(4'd2, 5, "len_add");
`endif

        // Randomized run with occasional resets and step_en gaps.
        for (int i = 0; i < 400; i++)
            apply(1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 4) != 0),
                  4'($urandom), 1'($urandom), 1'($urandom), "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
